// File: rtl/rpn_pkg.sv
// Shared opcodes, error codes and FSM state encoding for the RPN evaluator.
package rpn_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_NEG = 2'd3;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDER     = 2'd1;
    localparam logic [1:0] ERR_OVER      = 2'd2;
    localparam logic [1:0] ERR_MALFORMED = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        POP_B,
        POP_A,
        EXEC,
        CAP_NEG,
        FIN_POP,
        FIN_CAP,
        SKIP,
        DRAIN,
        DONE
    } rpn_state_e;

endpackage

// File: rtl/rpn_evaluator_alu.sv
// Combinational two's-complement ALU: ADD/SUB/MUL on (A,B), NEG on A, all modulo 2^N.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            default: y = '0 - a;
        endcase
    end

endmodule

// File: rtl/stack.sv
// LIFO of MAX_SIZE N-bit words; data_out is registered and updates on the pop edge.
module stack #(
    parameter int N        = 8,
    parameter int MAX_SIZE = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_out,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(MAX_SIZE);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] FULL_DEPTH = DW'(MAX_SIZE);

    logic [N-1:0]  mem [MAX_SIZE];
    logic [DW-1:0] sp_q, sp_d;
    logic [N-1:0]  data_out_q, data_out_d;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          push_ok, pop_ok;

    assign full     = (sp_q == FULL_DEPTH);
    assign empty    = (sp_q == '0);
    assign data_out = data_out_q;
    assign wr_idx   = sp_q[AW-1:0];
    assign rd_idx   = wr_idx - 1'b1;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    always_comb begin
        sp_d       = sp_q;
        data_out_d = data_out_q;
        if (push_ok) begin
            sp_d = sp_q + 1'b1;
        end else if (pop_ok) begin
            sp_d       = sp_q - 1'b1;
            data_out_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q       <= '0;
            data_out_q <= '0;
        end else begin
            sp_q       <= sp_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: rtl/rpn_evaluator.sv
// Postfix expression evaluator driving an external stack; one result and error code per expression.
module rpn_evaluator
    import rpn_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_SIZE = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic         tok_is_op,
    input  logic [N-1:0] tok_data,
    input  logic         tok_last,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic [1:0]   res_err,
    output logic         stk_push,
    output logic         stk_pop,
    output logic [N-1:0] stk_wdata,
    input  logic [N-1:0] stk_rdata,
    input  logic         stk_full,
    input  logic         stk_empty
);

    localparam int DW = $clog2(MAX_SIZE) + 1;
    localparam logic [DW-1:0] FULL_DEPTH = DW'(MAX_SIZE);

    rpn_state_e    state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [1:0]    err_q, err_d;
    logic [1:0]    op_q, op_d;
    logic          last_q, last_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  res_data_q, res_data_d;
    logic [1:0]    res_err_q, res_err_d;
    logic          alive_q, alive_d;

    logic [N-1:0]  alu_y;
    logic [DW-1:0] need;
    logic          take;

    rpn_alu #(.N(N)) u_alu (
        .op (op_q),
        .a  (stk_rdata),
        .b  (b_q),
        .y  (alu_y)
    );

    // alive_q keeps every handshake output low during and for one cycle after reset
    assign tok_ready = alive_q && ((state_q == IDLE) || (state_q == SKIP));
    assign take      = tok_valid && tok_ready;
    assign need      = (tok_data[1:0] == OP_NEG) ? DW'(1) : DW'(2);
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        err_d      = err_q;
        op_d       = op_q;
        last_d     = last_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        alive_d    = 1'b1;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_wdata  = '0;
        res_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (take && !tok_is_op) begin
                    if (depth_q == FULL_DEPTH) begin
                        if (err_q == ERR_NONE) err_d = ERR_OVER;
                    end else begin
                        stk_push  = 1'b1;
                        stk_wdata = tok_data;
                        depth_d   = depth_q + 1'b1;
                    end
                    if (tok_last) state_d = FIN_POP;
                end else if (take) begin
                    op_d   = tok_data[1:0];
                    last_d = tok_last;
                    if (depth_q < need) begin
                        if (err_q == ERR_NONE) err_d = ERR_UNDER;
                        state_d = tok_last ? DRAIN : SKIP;
                    end else begin
                        state_d = POP_B;
                    end
                end
            end
            POP_B: begin
                stk_pop = 1'b1;
                depth_d = depth_q - 1'b1;
                state_d = (op_q == OP_NEG) ? CAP_NEG : POP_A;
            end
            POP_A: begin
                stk_pop = 1'b1;
                depth_d = depth_q - 1'b1;
                b_d     = stk_rdata;
                state_d = EXEC;
            end
            EXEC, CAP_NEG: begin
                stk_push  = 1'b1;
                stk_wdata = alu_y;
                depth_d   = depth_q + 1'b1;
                state_d   = last_q ? FIN_POP : IDLE;
            end
            FIN_POP: begin
                // an earlier overflow leaves a well-formed stack but must still report
                if ((depth_q != DW'(1)) || (err_q != ERR_NONE)) begin
                    if (err_q == ERR_NONE) err_d = ERR_MALFORMED;
                    state_d = DRAIN;
                end else begin
                    stk_pop = 1'b1;
                    depth_d = '0;
                    state_d = FIN_CAP;
                end
            end
            FIN_CAP: begin
                res_data_d = stk_rdata;
                res_err_d  = ERR_NONE;
                state_d    = DONE;
            end
            SKIP: begin
                if (take && tok_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (depth_q != '0) begin
                    stk_pop = 1'b1;
                    depth_d = depth_q - 1'b1;
                end else begin
                    res_data_d = '0;
                    res_err_d  = err_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    err_d   = ERR_NONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            depth_q    <= '0;
            err_q      <= ERR_NONE;
            op_q       <= OP_ADD;
            last_q     <= 1'b0;
            b_q        <= '0;
            res_data_q <= '0;
            res_err_q  <= ERR_NONE;
            alive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            err_q      <= err_d;
            op_q       <= op_d;
            last_q     <= last_d;
            b_q        <= b_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            alive_q    <= alive_d;
        end
    end

    a_no_push_pop: assert property (@(posedge clk) disable iff (!rst_n) !(stk_push && stk_pop));
    a_full_agree:  assert property (@(posedge clk) disable iff (!rst_n) stk_full == (depth_q == FULL_DEPTH));
    a_empty_agree: assert property (@(posedge clk) disable iff (!rst_n) stk_empty == (depth_q == '0));

endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed and random expressions against a queue-based postfix reference model.
module tb_rpn_evaluator;

    localparam int N        = 8;
    localparam int MAX_SIZE = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tok_valid = 1'b0, tok_ready, tok_is_op = 1'b0, tok_last = 1'b0;
    logic [N-1:0] tok_data = '0;
    logic         res_valid, res_ready = 1'b0;
    logic [N-1:0] res_data;
    logic [1:0]   res_err;
    logic         stk_push, stk_pop, stk_full, stk_empty;
    logic [N-1:0] stk_wdata, stk_rdata;

    int n_vec = 0;
    int n_err = 0;
    int pop_total = 0;

    typedef struct {
        bit         is_op;
        logic [7:0] data;
    } tok_t;

    tok_t expr[$];

    always #5 clk = ~clk;

    always @(posedge clk) if (stk_pop) pop_total <= pop_total + 1;

    rpn_evaluator #(.N(N), .MAX_SIZE(MAX_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
        .tok_data(tok_data), .tok_last(tok_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
        .stk_rdata(stk_rdata), .stk_full(stk_full), .stk_empty(stk_empty)
    );

    stack #(.N(N), .MAX_SIZE(MAX_SIZE)) u_stack (
        .clk(clk), .rst_n(rst_n), .push(stk_push), .pop(stk_pop),
        .data_in(stk_wdata), .data_out(stk_rdata), .full(stk_full), .empty(stk_empty)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void num(input logic [7:0] v);
        tok_t t;
        t.is_op = 1'b0;
        t.data  = v;
        expr.push_back(t);
    endfunction

    function automatic void opr(input logic [1:0] o);
        tok_t t;
        t.is_op = 1'b1;
        t.data  = {6'b0, o};
        expr.push_back(t);
    endfunction

    // Reference: evaluate the token list with a queue as the stack
    task automatic model(output logic [7:0] rd, output logic [1:0] re);
        logic [7:0] st[$];
        logic [7:0] t8;
        int err, need, a, b, r;
        bit skip;
        err  = 0;
        skip = 0;
        foreach (expr[i]) begin
            if (skip) continue;
            if (!expr[i].is_op) begin
                if (st.size() == MAX_SIZE) begin
                    if (err == 0) err = 2;
                end else begin
                    st.push_back(expr[i].data);
                end
            end else begin
                need = (expr[i].data[1:0] == 2'd3) ? 1 : 2;
                if (st.size() < need) begin
                    if (err == 0) err = 1;
                    skip = 1;
                end else begin
                    t8 = st.pop_back();
                    b  = int'($signed(t8));
                    a  = 0;
                    if (need == 2) begin
                        t8 = st.pop_back();
                        a  = int'($signed(t8));
                    end
                    case (expr[i].data[1:0])
                        2'd0:    r = a + b;
                        2'd1:    r = a - b;
                        2'd2:    r = a * b;
                        default: r = -b;
                    endcase
                    st.push_back(r[7:0]);
                end
            end
        end
        if (err != 0) begin
            rd = 8'd0;
            re = 2'(err);
        end else if (st.size() != 1) begin
            rd = 8'd0;
            re = 2'd3;
        end else begin
            rd = st[0];
            re = 2'd0;
        end
    endtask

    task automatic send_tok(input tok_t t, input bit last);
        int waited;
        waited    = 0;
        tok_valid = 1'b1;
        tok_is_op = t.is_op;
        tok_data  = t.data;
        tok_last  = last;
        while (!tok_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!tok_ready) check_eq("tok_accept_timeout", {31'b0, tok_ready}, 32'd1);
        else tick();
        tok_valid = 1'b0;
        tok_last  = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [7:0] ed, input logic [1:0] ee,
                              input int hold);
        int waited;
        waited = 0;
        while (!res_valid && waited < 300) begin
            tick();
            waited++;
        end
        check_eq({tag, "_valid"}, {31'b0, res_valid}, 32'd1);
        check_eq({tag, "_data"}, {24'b0, res_data}, {24'b0, ed});
        check_eq({tag, "_err"}, {30'b0, res_err}, {30'b0, ee});
        check_eq({tag, "_empty"}, {31'b0, stk_empty}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq({tag, "_hold_valid"}, {31'b0, res_valid}, 32'd1);
            check_eq({tag, "_hold_data"}, {24'b0, res_data}, {24'b0, ed});
            check_eq({tag, "_hold_err"}, {30'b0, res_err}, {30'b0, ee});
            check_eq({tag, "_hold_ready"}, {31'b0, tok_ready}, 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, {31'b0, res_valid}, 32'd0);
    endtask

    task automatic run_expr(input string tag, input bit use_exp, input logic [7:0] ed,
                            input logic [1:0] ee, input int gaps, input int hold);
        logic [7:0] md;
        logic [1:0] me;
        if (use_exp) begin
            md = ed;
            me = ee;
        end else begin
            model(md, me);
        end
        foreach (expr[i]) begin
            if (gaps > 0) repeat ($urandom_range(0, gaps)) tick();
            send_tok(expr[i], i == expr.size() - 1);
        end
        get_result(tag, md, me, hold);
    endtask

    task automatic gen_random();
        int len, d, r;
        expr.delete();
        d   = 0;
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 9);
            if (r < 1) begin
                opr(2'($urandom_range(0, 3)));
                d = (d > 0) ? d - 1 : 0;
            end else if (d >= 2 && r < 6) begin
                opr(2'($urandom_range(0, 2)));
                d--;
            end else if (d >= 1 && r == 6) begin
                opr(2'd3);
            end else begin
                num(8'($urandom));
                d++;
            end
        end
        if ($urandom_range(0, 3) != 0) begin
            if (d == 0) num(8'($urandom));
            while (d > 1) begin
                opr(2'($urandom_range(0, 2)));
                d--;
            end
        end
    endtask

    initial begin
        int pops0;

        repeat (3) tick();
        check_eq("rst_tok_ready", {31'b0, tok_ready}, 32'd0);
        check_eq("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check_eq("rst_stk_push", {31'b0, stk_push}, 32'd0);
        check_eq("rst_stk_pop", {31'b0, stk_pop}, 32'd0);
        check_eq("rst_res_data", {24'b0, res_data}, 32'd0);
        check_eq("rst_res_err", {30'b0, res_err}, 32'd0);
        check_eq("rst_wdata", {24'b0, stk_wdata}, 32'd0);
        rst_n = 1'b1;
        tick();

        expr.delete(); num(8'd3); num(8'd4); opr(2'd0); num(8'd2); opr(2'd2);
        run_expr("add_mul", 1'b1, 8'd14, 2'd0, 0, 0);

        expr.delete(); num(8'd5); num(8'hFD); opr(2'd1); opr(2'd3);
        run_expr("sub_neg", 1'b1, 8'hF8, 2'd0, 0, 0);

        expr.delete(); num(8'd100); num(8'd100); opr(2'd2);
        run_expr("mul_wrap", 1'b1, 8'd16, 2'd0, 1, 0);

        expr.delete(); num(8'h80); opr(2'd3);
        run_expr("neg_min", 1'b1, 8'h80, 2'd0, 0, 0);

        expr.delete(); num(8'd1); opr(2'd0); num(8'd9);
        run_expr("underflow", 1'b1, 8'd0, 2'd1, 0, 0);
        expr.delete(); num(8'd2);
        run_expr("after_under", 1'b1, 8'd2, 2'd0, 0, 0);

        expr.delete();
        for (int i = 0; i < MAX_SIZE + 1; i++) num(8'(i + 1));
        pops0 = pop_total;
        run_expr("overflow", 1'b1, 8'd0, 2'd2, 0, 0);
        check_eq("overflow_pops", 32'(pop_total - pops0), 32'd16);

        expr.delete(); num(8'd1); num(8'd2);
        pops0 = pop_total;
        run_expr("malformed", 1'b1, 8'd0, 2'd3, 0, 5);
        check_eq("malformed_pops", 32'(pop_total - pops0), 32'd2);

        expr.delete(); num(8'd7); num(8'd8); opr(2'd0);
        foreach (expr[i]) send_tok(expr[i], 1'b0);
        tick();
        tick();
        check_eq("exec_push", {31'b0, stk_push}, 32'd1);
        check_eq("exec_wdata", {24'b0, stk_wdata}, 32'd15);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_push", {31'b0, stk_push}, 32'd0);
        check_eq("midrst_pop", {31'b0, stk_pop}, 32'd0);
        check_eq("midrst_ready", {31'b0, tok_ready}, 32'd0);
        check_eq("midrst_valid", {31'b0, res_valid}, 32'd0);
        check_eq("midrst_wdata", {24'b0, stk_wdata}, 32'd0);
        check_eq("midrst_res", {24'b0, res_data}, 32'd0);
        check_eq("midrst_empty", {31'b0, stk_empty}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        expr.delete(); num(8'd4);
        run_expr("after_rst", 1'b1, 8'd4, 2'd0, 0, 0);

        for (int e = 0; e < 60; e++) begin
            gen_random();
            run_expr("rand", 1'b0, 8'd0, 2'd0, 2, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
